cam_update_ctrl: RTL and testbench

CAM_UPDATE_CTRL -- requirements
Module: cam_update_ctrl

---
 rtl/cam_update_ctrl.sv | 135 +++++++++++++
 tb/tb_cam_update_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cam_update_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cam_update_ctrl
//  Description : Arbitrates CAM update requests round-robin, issues one
//                update strobe per accepted request, and spaces updates so the
//                CAM result settles before the next one. The optional macro
//                CAM_UPDATE_FWD_EN forwards the in-flight key/value to hit_o
//                while the raw CAM result may be stale.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_update_ctrl #(
   parameter int NUM_REQ         = 2,
   parameter int PACKS_OF_5_BITS = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid_i,
   input  logic [NUM_REQ*5*PACKS_OF_5_BITS-1:0] req_key_i,
   input  logic [NUM_REQ-1:0]               req_key_valid_i,
   output logic [NUM_REQ-1:0]               req_ready_o,
   output logic                             update_o,
   output logic [5*PACKS_OF_5_BITS-1:0]     set_key_o,
   output logic                             set_key_valid_o,
   input  logic [5*PACKS_OF_5_BITS-1:0]     cmp_key_i,
   input  logic                             cam_hit_i,
   output logic                             hit_o,
   output logic                             busy_o
);

   localparam int KW  = 5 * PACKS_OF_5_BITS;
   localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [RRW-1:0]  r_rr;
   logic [RRW-1:0]  w_rr_nxt;
   logic [KW-1:0]   r_pend_key;
   logic            r_pend_val;
   logic [RRW-1:0]  w_gnt_idx;
   logic            w_found;
   logic            w_accept;

   // Round-robin search starting at r_rr; grant only in IDLE and out of reset
   always_comb begin
      int             w_idx;
      logic [RRW-1:0] w_idx_t;
      w_idx       = 0;
      w_idx_t     = '0;
      w_gnt_idx   = '0;
      w_found     = 1'b0;
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx = int'(r_rr) + i;
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         w_idx_t = RRW'(w_idx);
         if (!w_found && req_valid_i[w_idx_t]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_idx_t;
         end
      end
      if ((r_state == ST_IDLE) && !rst && w_found) begin
         req_ready_o[w_gnt_idx] = 1'b1;
      end
   end

   // Grant implies valid, so any ready bit is an accepted transfer
   assign w_accept = |req_ready_o;
   assign w_rr_nxt = (w_gnt_idx == RRW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + RRW'(1));

   // Next-state and strobe decode; update is suppressed while in reset
   always_comb begin
      w_state_nxt = r_state;
      update_o    = 1'b0;
      busy_o      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            update_o    = !rst;
            busy_o      = 1'b1;
            w_state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            busy_o      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register, round-robin pointer and pending key/value capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rr       <= '0;
         r_pend_key <= '0;
         r_pend_val <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_rr       <= w_rr_nxt;
            r_pend_key <= req_key_i[w_gnt_idx*KW +: KW];
            r_pend_val <= req_key_valid_i[w_gnt_idx];
         end
      end
   end

   // Pending registers change only on acceptance in IDLE, so the following
   // cycle is always ISSUE; driving them straight out gives hold-last-value.
   assign set_key_o       = r_pend_key;
   assign set_key_valid_o = r_pend_val;

`ifdef CAM_UPDATE_FWD_EN
   // Forward the in-flight value while the CAM may still return stale data
   assign hit_o = (busy_o && (cmp_key_i == r_pend_key)) ? r_pend_val : cam_hit_i;
`else
   assign hit_o = cam_hit_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_update_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cam_update_ctrl
//  Description : Table-driven bench for cam_update_ctrl (NUM_REQ=2, KW=20)
//                plus a reset-mid-update sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_update_ctrl;

   localparam int KW = 20;
`ifdef CAM_UPDATE_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid_i;
   logic [2*KW-1:0] req_key_i;
   logic [1:0]    req_key_valid_i;
   logic [1:0]    req_ready_o;
   logic          update_o;
   logic [KW-1:0] set_key_o;
   logic          set_key_valid_o;
   logic [KW-1:0] cmp_key_i;
   logic          cam_hit_i;
   logic          hit_o;
   logic          busy_o;

   int n_chk = 0;
   int n_err = 0;

   cam_update_ctrl #(.NUM_REQ(2), .PACKS_OF_5_BITS(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid_i),
      .req_key_i       (req_key_i),
      .req_key_valid_i (req_key_valid_i),
      .req_ready_o     (req_ready_o),
      .update_o        (update_o),
      .set_key_o       (set_key_o),
      .set_key_valid_o (set_key_valid_o),
      .cmp_key_i       (cmp_key_i),
      .cam_hit_i       (cam_hit_i),
      .hit_o           (hit_o),
      .busy_o          (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic [1:0]    vld;
      logic [KW-1:0] k0;
      logic [KW-1:0] k1;
      logic [1:0]    kv;
      logic [KW-1:0] cmp;
      logic          ch;
      logic [1:0]    e_rdy;
      logic          e_upd;
      logic [KW-1:0] e_sk;
      logic          e_skv;
      logic          e_busy;
      logic          e_hit;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] v, input logic [KW-1:0] k0,
                        input logic [KW-1:0] k1, input logic [1:0] kv,
                        input logic [KW-1:0] cmp, input logic ch);
      rst             = r;
      req_valid_i     = v;
      req_key_i       = {k1, k0};
      req_key_valid_i = kv;
      cmp_key_i       = cmp;
      cam_hit_i       = ch;
   endtask

   initial begin
      //           rst   vld    k0        k1        kv     cmp       ch  | rdy   upd  sk        skv   busy  hit
      tbl[0]  = '{1'b1, 2'b00, 20'h0,     20'h0,     2'b00, 20'h0,     1'b0, 2'b00, 1'b0, 20'h0,     1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 2'b11, 20'h0,     20'h0,     2'b00, 20'h0,     1'b0, 2'b00, 1'b0, 20'h0,     1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'h00007, 1'b1, 2'b00, 1'b0, 20'h0,     1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 2'b01, 20'h12345, 20'h0,     2'b01, 20'h0,     1'b0, 2'b01, 1'b0, 20'h0,     1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'h12345, 1'b0, 2'b00, 1'b1, 20'h12345, 1'b1, 1'b1, FWD};
      tbl[5]  = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'h12345, 1'b0, 2'b00, 1'b0, 20'h12345, 1'b1, 1'b1, FWD};
      tbl[6]  = '{1'b0, 2'b11, 20'hAAAAA, 20'h0BCDE, 2'b10, 20'h12345, 1'b1, 2'b10, 1'b0, 20'h12345, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 2'b11, 20'hAAAAA, 20'h0BCDE, 2'b10, 20'h0BCDE, 1'b0, 2'b00, 1'b1, 20'h0BCDE, 1'b1, 1'b1, FWD};
      tbl[8]  = '{1'b0, 2'b11, 20'hAAAAA, 20'h0BCDE, 2'b10, 20'h00001, 1'b0, 2'b00, 1'b0, 20'h0BCDE, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 2'b11, 20'hAAAAA, 20'h0BCDE, 2'b10, 20'h00001, 1'b0, 2'b01, 1'b0, 20'h0BCDE, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'hAAAAA, 1'b1, 2'b00, 1'b1, 20'hAAAAA, 1'b0, 1'b1, ~FWD};
      tbl[11] = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'hAAAAA, 1'b1, 2'b00, 1'b0, 20'hAAAAA, 1'b0, 1'b1, ~FWD};
      tbl[12] = '{1'b0, 2'b01, 20'h00F0F, 20'h0,     2'b01, 20'hAAAAA, 1'b1, 2'b01, 1'b0, 20'hAAAAA, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'h0,     1'b0, 2'b00, 1'b1, 20'h00F0F, 1'b1, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'h0,     1'b0, 2'b00, 1'b0, 20'h00F0F, 1'b1, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 2'b10, 20'h0,     20'h11111, 2'b10, 20'h0,     1'b0, 2'b10, 1'b0, 20'h00F0F, 1'b1, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'h0,     1'b0, 2'b00, 1'b1, 20'h11111, 1'b1, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'h0,     1'b0, 2'b00, 1'b0, 20'h11111, 1'b1, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 2'b00, 20'h0,     20'h0,     2'b00, 20'h0,     1'b0, 2'b00, 1'b0, 20'h11111, 1'b1, 1'b0, 1'b0};

      drive(1'b1, 2'b00, '0, '0, 2'b00, '0, 1'b0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         #1;
         drive(tbl[i].rst, tbl[i].vld, tbl[i].k0, tbl[i].k1, tbl[i].kv, tbl[i].cmp, tbl[i].ch);
         @(negedge clk);
         chk("ready",  i, 32'(req_ready_o),     32'(tbl[i].e_rdy));
         chk("update", i, 32'(update_o),        32'(tbl[i].e_upd));
         chk("setkey", i, 32'(set_key_o),       32'(tbl[i].e_sk));
         chk("setval", i, 32'(set_key_valid_o), 32'(tbl[i].e_skv));
         chk("busy",   i, 32'(busy_o),          32'(tbl[i].e_busy));
         chk("hit",    i, 32'(hit_o),           32'(tbl[i].e_hit));
         @(posedge clk);
      end

      // Reset mid-update: grant req0 (pointer moves to 1), then reset in ISSUE
      #1;
      drive(1'b0, 2'b01, 20'h54321, 20'h0, 2'b01, 20'h0, 1'b0);
      @(negedge clk);
      chk("rst_mid_grant", 100, 32'(req_ready_o), 32'h1);
      @(posedge clk);
      #1;
      drive(1'b1, 2'b00, '0, '0, 2'b00, '0, 1'b0);
      @(negedge clk);
      chk("rst_mid_ready", 101, 32'(req_ready_o), 32'h0);
      @(posedge clk);
      #1;
      drive(1'b0, 2'b00, '0, '0, 2'b00, '0, 1'b0);
      @(negedge clk);
      chk("rst_mid_upd",    102, 32'(update_o),        32'h0);
      chk("rst_mid_busy",   102, 32'(busy_o),          32'h0);
      chk("rst_mid_setkey", 102, 32'(set_key_o),       32'h0);
      chk("rst_mid_setval", 102, 32'(set_key_valid_o), 32'h0);
      for (int j = 0; j < 4; j++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_no_reissue", 103 + j, 32'(update_o), 32'h0);
      end
      @(posedge clk);
      #1;
      drive(1'b0, 2'b11, 20'h0000A, 20'h0000B, 2'b11, '0, 1'b0);
      @(negedge clk);
      chk("rst_rr_zero", 107, 32'(req_ready_o), 32'h1);
      @(posedge clk);
      #1;
      drive(1'b0, 2'b00, '0, '0, 2'b00, '0, 1'b0);
      @(negedge clk);
      chk("post_rst_upd", 108, 32'(update_o),  32'h1);
      chk("post_rst_key", 108, 32'(set_key_o), 32'h0000A);
      @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
